// File: rtl/vram_pixel_packer_if.sv
// Pixel stream in and VRAM byte-write bus out of the pixel packer.
// The master modport is the packer side; slave is the source/arbiter side.
interface vram_pixel_packer_if #(
   parameter int unsigned ADDR_WIDTH = 13
);
   logic                  pixel_valid;
   logic [1:0]            pixel_value;
   logic                  pixel_last;
   logic                  pixel_ready;
   logic                  vram_req;
   logic [ADDR_WIDTH-1:0] vram_addr;
   logic [7:0]            vram_data;
   logic                  vram_ack;

   modport master (
      input  pixel_valid, pixel_value, pixel_last, vram_ack,
      output pixel_ready, vram_req, vram_addr, vram_data
   );

   modport slave (
      output pixel_valid, pixel_value, pixel_last, vram_ack,
      input  pixel_ready, vram_req, vram_addr, vram_data
   );
endinterface

// File: rtl/vram_pixel_packer.sv
// Packs 1bpp/2bpp pixels MSB-first into VRAM bytes and writes them through a
// one-deep holding stage plus one pending byte over a req/ack handshake.
module vram_pixel_packer #(
   parameter int unsigned ADDR_WIDTH = 13
) (
   input  logic                  pixel_clock,
   input  logic                  reset,
   input  logic [1:0]            mode,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic                  frame_start,
   output logic                  idle,
   vram_pixel_packer_if.master   bus
);
   logic [7:0]            r_shift;
   logic [2:0]            r_cnt;
   logic [1:0]            r_mode;
   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic                  r_pend_full;
   logic [ADDR_WIDTH-1:0] r_pend_addr;
   logic [7:0]            r_pend_data;
   logic                  r_req;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [7:0]            r_data;

   logic                  w_accept;
   logic [1:0]            w_mode_raw;
   logic [1:0]            w_mode;
   logic [7:0]            w_bits;
   logic [7:0]            w_byte;
   logic                  w_full;
   logic                  w_complete;
   logic                  w_hold_free;

   assign bus.pixel_ready = !r_pend_full && !frame_start;
   assign bus.vram_req    = r_req;
   assign bus.vram_addr   = r_addr;
   assign bus.vram_data   = r_data;
   assign idle            = (r_cnt == 3'd0) && !r_pend_full && !r_req;

   assign w_accept = bus.pixel_valid && bus.pixel_ready;

   // Mode is taken live on the first pixel of a byte, then held; 11 aliases 00.
   always_comb begin
      w_mode_raw  = (r_cnt == 3'd0) ? mode : r_mode;
      w_mode      = (w_mode_raw == 2'b11) ? 2'b00 : w_mode_raw;
      w_bits      = 8'h00;
      w_full      = 1'b0;
      case (w_mode)
         2'b00: begin
            w_bits = {7'b0, bus.pixel_value[0]} << (3'd7 - r_cnt);
            w_full = (r_cnt == 3'd7);
         end
         2'b01: begin
            w_bits = {6'b0, bus.pixel_value} << (3'd6 - {r_cnt[1:0], 1'b0});
            w_full = (r_cnt == 3'd3);
         end
         default: begin
            w_bits = {7'b0, bus.pixel_value[0]} << (3'd3 - r_cnt);
            w_full = (r_cnt == 3'd3);
         end
      endcase
      w_byte      = r_shift | w_bits;
      w_complete  = w_accept && (bus.pixel_last || w_full);
      w_hold_free = !r_req || bus.vram_ack;
   end

   always_ff @(posedge pixel_clock) begin
      if (reset) begin
         r_shift     <= 8'h00;
         r_cnt       <= 3'd0;
         r_mode      <= 2'b00;
         r_wr_addr   <= '0;
         r_pend_full <= 1'b0;
         r_pend_addr <= '0;
         r_pend_data <= 8'h00;
         r_req       <= 1'b0;
         r_addr      <= '0;
         r_data      <= 8'h00;
      end else begin
         // Retire the holding byte; the pending byte, if any, takes its place.
         if (r_req && bus.vram_ack) begin
            if (r_pend_full) begin
               r_addr      <= r_pend_addr;
               r_data      <= r_pend_data;
               r_pend_full <= 1'b0;
            end else begin
               r_req <= 1'b0;
            end
         end

         if (frame_start) begin
            r_shift   <= 8'h00;
            r_cnt     <= 3'd0;
            r_wr_addr <= base_addr;
         end else if (w_accept) begin
            if (r_cnt == 3'd0) r_mode <= mode;
            if (w_complete) begin
               r_shift   <= 8'h00;
               r_cnt     <= 3'd0;
               r_wr_addr <= r_wr_addr + ADDR_WIDTH'(1);
               // Accept implies no pending byte, so at most one slot is taken here.
               if (w_hold_free) begin
                  r_addr <= r_wr_addr;
                  r_data <= w_byte;
                  r_req  <= 1'b1;
               end else begin
                  r_pend_addr <= r_wr_addr;
                  r_pend_data <= w_byte;
                  r_pend_full <= 1'b1;
               end
            end else begin
               r_shift <= w_byte;
               r_cnt   <= r_cnt + 3'd1;
            end
         end
      end
   end
endmodule
